// File: rtl/serial_word_assembler.sv
// Assembles an MSB-first serial bit stream into a right-justified word of
// 1..MAX_LEN bits and offers it downstream with a valid/ready handshake.
module serial_word_assembler #(
    parameter int MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bit_in,
    input  logic               bit_valid,
    input  logic               frame_start,
    input  logic               frame_end,
    output logic               bit_ready,
    output logic [MAX_LEN-1:0] data,
    output logic [5:0]         word_len,
    output logic               data_valid,
    input  logic               data_ready,
    output logic               err_sync,
    output logic               err_overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam logic [5:0] CNT_MAX = 6'(MAX_LEN);

    state_t               state_q, state_d;
    logic [MAX_LEN-1:0]   sr_q, sr_d;
    logic [5:0]           cnt_q, cnt_d;
    logic                 err_sync_q, err_sync_d;
    logic                 err_ovf_q, err_ovf_d;
    logic                 bit_ready_q, bit_ready_d;
    logic                 data_valid_q, data_valid_d;
    logic [MAX_LEN-1:0]   data_q, data_d;
    logic [5:0]           word_len_q, word_len_d;
    logic                 xfer;

    assign xfer = bit_valid && (state_q != HOLD);

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        err_sync_d = 1'b0;
        err_ovf_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (frame_start) begin
                        sr_d    = {{(MAX_LEN-1){1'b0}}, bit_in};
                        cnt_d   = 6'd1;
                        state_d = frame_end ? HOLD : COLLECT;
                    end else begin
                        err_sync_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (xfer) begin
                    if (frame_start) begin
                        err_sync_d = 1'b1;
                        sr_d       = {{(MAX_LEN-1){1'b0}}, bit_in};
                        cnt_d      = 6'd1;
                        state_d    = frame_end ? HOLD : COLLECT;
                    end else if (cnt_q < CNT_MAX) begin
                        sr_d  = {sr_q[MAX_LEN-2:0], bit_in};
                        cnt_d = cnt_q + 6'd1;
                        if (frame_end) state_d = HOLD;
                    end else begin
                        err_ovf_d = 1'b1;
                        sr_d      = '0;
                        cnt_d     = '0;
                        state_d   = frame_end ? IDLE : DRAIN;
                    end
                end
            end
            DRAIN: begin
                // A new frame_start rescues the stream without a sync error.
                if (xfer) begin
                    if (frame_start) begin
                        sr_d    = {{(MAX_LEN-1){1'b0}}, bit_in};
                        cnt_d   = 6'd1;
                        state_d = frame_end ? HOLD : COLLECT;
                    end else if (frame_end) begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (data_ready) begin
                    state_d = IDLE;
                    sr_d    = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        bit_ready_d  = (state_d != HOLD);
        data_valid_d = (state_d == HOLD);
        data_d       = (state_d == HOLD) ? sr_d  : '0;
        word_len_d   = (state_d == HOLD) ? cnt_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            err_sync_q   <= 1'b0;
            err_ovf_q    <= 1'b0;
            bit_ready_q  <= 1'b1;
            data_valid_q <= 1'b0;
            data_q       <= '0;
            word_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            err_sync_q   <= err_sync_d;
            err_ovf_q    <= err_ovf_d;
            bit_ready_q  <= bit_ready_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            word_len_q   <= word_len_d;
        end
    end

    assign bit_ready    = bit_ready_q;
    assign data_valid   = data_valid_q;
    assign data         = data_q;
    assign word_len     = word_len_q;
    assign err_sync     = err_sync_q;
    assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Scoreboard bench for serial_word_assembler: frames are queued as they are
// driven and compared when the word is handed off downstream.
module tb_serial_word_assembler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_end = 1'b0;
    logic        data_ready = 1'b0;
    logic        bit_ready;
    logic [31:0] data;
    logic [5:0]  word_len;
    logic        data_valid;
    logic        err_sync;
    logic        err_overflow;

    serial_word_assembler #(.MAX_LEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .frame_end(frame_end), .bit_ready(bit_ready),
        .data(data), .word_len(word_len), .data_valid(data_valid),
        .data_ready(data_ready), .err_sync(err_sync), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [5:0]  l;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n_sync = 0;
    int   n_ovf  = 0;
    int   n_hs   = 0;

    // Monitor: pop the scoreboard on every handshake, sample on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (err_sync) n_sync++;
            if (err_overflow) n_ovf++;
            if (data_valid && data_ready) begin
                n_hs++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got data=%h len=%0d, required no word", data, word_len);
                end else begin
                    e = sb.pop_front();
                    if (data !== e.d || word_len !== e.l) begin
                        errors++;
                        $display("FAIL word: got data=%h len=%0d, required data=%h len=%0d",
                                 data, word_len, e.d, e.l);
                    end else begin
                        $display("word data=%h len=%0d ok", data, word_len);
                    end
                end
            end
            if (!data_valid) begin
                checks++;
                if (data !== 32'h0 || word_len !== 6'd0) begin
                    errors++;
                    $display("FAIL idle_zero: got data=%h len=%0d, required 0", data, word_len);
                end
            end
        end
    end

    task automatic idle_in();
        bit_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0; bit_in = 1'b0;
    endtask

    // Present one bit and return 1ns after the edge that accepted it.
    task automatic send_bit(input logic b, input logic s, input logic e);
        int t;
        bit_in = b; frame_start = s; frame_end = e; bit_valid = 1'b1;
        t = 0;
        while (bit_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 50) begin
            checks++; errors++;
            $display("FAIL bit_ready_timeout: got bit_ready=%b, required 1 within 50 cycles", bit_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [63:0] bits, input int n, input bit push);
        logic [63:0] m;
        exp_t        x;
        m = (64'd1 << n) - 64'd1;
        if (push) begin
            x.d = 32'(bits & m);
            x.l = 6'(n);
            sb.push_back(x);
        end
        for (int i = n - 1; i >= 0; i--)
            send_bit(bits[i], (i == n - 1), (i == 0));
        idle_in();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        wait_cycles(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d pending words, required 0", name, sb.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bit_ready !== 1'b1 || data_valid !== 1'b0 || data !== 32'h0 ||
            word_len !== 6'd0 || err_sync !== 1'b0 || err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL %s: got rdy=%b vld=%b data=%h len=%0d es=%b eo=%b, required rdy=1 rest 0",
                     name, bit_ready, data_valid, data, word_len, err_sync, err_overflow);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cycles(2);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        wait_cycles(1);
        check_reset_outputs("after_reset");
    endtask

    task automatic test_basic();
        int hs0;
        data_ready = 1'b1;
        hs0 = n_hs;
        send_frame(64'b1001, 4, 1'b1);
        checks++;
        if (data_valid !== 1'b1 || data !== 32'h9 || word_len !== 6'd4) begin
            errors++;
            $display("FAIL basic_valid_latency: got vld=%b data=%h len=%0d, required 1 9 4",
                     data_valid, data, word_len);
        end
        wait_cycles(1);
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_width: got vld=%b, required 0 after one cycle", data_valid);
        end
        send_frame(64'b110, 3, 1'b1);
        check_drained("basic");
        checks++;
        if (n_hs - hs0 !== 2) begin
            errors++;
            $display("FAIL basic_handshakes: got %0d, required 2", n_hs - hs0);
        end
    endtask

    task automatic test_hold_stall();
        exp_t x;
        data_ready = 1'b0;
        send_frame(64'hA000_0005, 32, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (data_valid !== 1'b1 || data !== 32'hA000_0005 || word_len !== 6'd32 || bit_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: cycle %0d got vld=%b data=%h len=%0d rdy=%b, required 1 a0000005 32 0",
                         i, data_valid, data, word_len, bit_ready);
            end
            if (i == 1) begin
                x.d = 32'h5; x.l = 6'd3;
                sb.push_back(x);
                bit_in = 1'b1; frame_start = 1'b1; frame_end = 1'b0; bit_valid = 1'b1;
            end
            wait_cycles(1);
        end
        data_ready = 1'b1;
        wait_cycles(1);
        checks++;
        if (data_valid !== 1'b0 || bit_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got vld=%b rdy=%b, required 0 1", data_valid, bit_ready);
        end
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b1);
        idle_in();
        check_drained("hold");
    endtask

    task automatic test_one_bit();
        exp_t x;
        data_ready = 1'b1;
        x.d = 32'h1; x.l = 6'd1;
        sb.push_back(x);
        send_bit(1'b1, 1'b1, 1'b1);
        send_frame(64'b10, 2, 1'b1);
        check_drained("one_bit");
    endtask

    task automatic test_overflow();
        int hs0, ovf0;
        logic [63:0] bits;
        data_ready = 1'b1;
        hs0 = n_hs; ovf0 = n_ovf;
        bits = {$urandom(), $urandom()};
        for (int i = 0; i < 35; i++) begin
            send_bit(bits[i], (i == 0), (i == 34));
            if (i == 31 || i == 32) begin
                checks++;
                if (err_overflow !== (i == 32)) begin
                    errors++;
                    $display("FAIL overflow_pulse: after bit %0d got %b, required %b", i + 1, err_overflow, (i == 32));
                end
            end
        end
        idle_in();
        wait_cycles(2);
        checks++;
        if (n_hs != hs0 || n_ovf != ovf0 + 1) begin
            errors++;
            $display("FAIL overflow_counts: got hs=%0d ovf=%0d, required 0 1", n_hs - hs0, n_ovf - ovf0);
        end
        send_frame(64'b101, 3, 1'b1);
        check_drained("overflow");
    endtask

    task automatic test_sync();
        int s0;
        exp_t x;
        data_ready = 1'b1;
        s0 = n_sync;
        send_bit(1'b1, 1'b0, 1'b0);
        idle_in();
        checks++;
        if (err_sync !== 1'b1 || bit_ready !== 1'b1 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL sync_idle: got es=%b rdy=%b vld=%b, required 1 1 0", err_sync, bit_ready, data_valid);
        end
        wait_cycles(1);
        x.d = 32'h6; x.l = 6'd3;
        sb.push_back(x);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        checks++;
        if (err_sync !== 1'b1) begin
            errors++;
            $display("FAIL sync_restart: got es=%b, required 1", err_sync);
        end
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b1);
        idle_in();
        check_drained("sync");
        checks++;
        if (n_sync - s0 !== 2) begin
            errors++;
            $display("FAIL sync_count: got %0d, required 2", n_sync - s0);
        end
    endtask

    task automatic test_reset_mid();
        data_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_bit(1'b1, (i == 0), 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_collect");
        idle_in();
        wait_cycles(1);
        rst_n = 1'b1;
        send_frame(64'b1101, 4, 1'b1);
        check_drained("reset_collect");

        data_ready = 1'b0;
        send_frame(64'b111, 3, 1'b0);
        checks++;
        if (data_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold_pre: got vld=%b, required 1", data_valid);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_hold");
        wait_cycles(1);
        rst_n = 1'b1;
        data_ready = 1'b1;
        send_frame(64'b1011, 4, 1'b1);
        check_drained("reset_hold");
    endtask

    task automatic test_back_to_back();
        logic [63:0] bits;
        int          n;
        data_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n = (k == 0) ? 32 : int'($urandom_range(1, 32));
            bits = {32'h0, $urandom()};
            send_frame(bits, n, 1'b1);
        end
        check_drained("back_to_back");
    endtask

    initial begin
        idle_in();
        #2;
        test_reset();
        test_basic();
        test_hold_stall();
        test_one_bit();
        test_overflow();
        test_sync();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
